// File: rtl/axi_pkg.sv
// Shared AXI read-channel types: burst encodings, response codes, responder FSM
// states and the per-beat address arithmetic for FIXED/INCR/WRAP bursts.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [63:0] ERR_DATA    = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } resp_state_t;

    // Only power-of-two WRAP lengths wrap; anything else (and burst code 11) steps like INCR.
    function automatic logic [63:0] next_burst_addr(
        input logic [63:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        logic [63:0] sum;
        logic [63:0] mask;
        step = 64'd1 << size;
        sum  = addr + step;
        mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        next_burst_addr = sum;
        if (burst == BURST_FIXED) begin
            next_burst_addr = addr;
        end else if (burst == BURST_WRAP &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            next_burst_addr = (addr & ~mask) | (sum & mask);
        end
    endfunction

endpackage

// File: rtl/axi_resp_mem.sv
// Word-addressed 64-bit memory with one registered read port and one write port.
// A same-edge read and write of one word returns the old contents.
module axi_resp_mem #(
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
    output logic [63:0]                  rd_data,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
    input  logic [63:0]                  wr_data
);

    logic [63:0] mem [MEM_WORDS];

    // The array is never cleared by reset so preloaded images survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-channel slave serving one burst at a time from an internal preloadable memory.
// Define AXI_RESP_ERR_EN to answer out-of-range beats with SLVERR instead of aliasing.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic        s_axi_rlast,
    output logic [1:0]  s_axi_rresp,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [63:0] ld_data,
    output resp_state_t dbg_state
);

    localparam int AW = $clog2(MEM_WORDS);

    // Handshakes: a transfer occurs on a rising edge where valid && ready;
    // R payload holds steady while rvalid && !rready.
    resp_state_t state, state_next;
    logic [63:0] addr_q, step_addr, rd_addr, mem_q;
    logic [7:0]  len_q, beat_cnt, lat_cnt;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        arready_q, ar_fire, r_fire, rd_en, ld_we;

    function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
        return AW'((a - BASE_ADDR) >> 3);
    endfunction

    assign ar_fire   = s_axi_arvalid && arready_q && (state == IDLE);
    assign r_fire    = (state == BURST) && s_axi_rready;
    assign step_addr = next_burst_addr(addr_q, len_q, size_q, burst_q);
    assign dbg_state = state;
    assign s_axi_arready = arready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ar_fire) state_next = WAIT;
            WAIT:    if (lat_cnt == 8'd0) state_next = BURST;
            BURST:   if (r_fire && beat_cnt == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat 0 is read on the WAIT->BURST edge; later beats are read on the accepting edge.
    always_comb begin
        s_axi_rvalid = (state == BURST);
        s_axi_rlast  = (state == BURST) && (beat_cnt == 8'd0);
        rd_en        = 1'b0;
        rd_addr      = addr_q;
        if (state == WAIT && lat_cnt == 8'd0) begin
            rd_en = 1'b1;
        end else if (r_fire && beat_cnt != 8'd0) begin
            rd_en   = 1'b1;
            rd_addr = step_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arready_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
        end else begin
            arready_q <= (state_next == IDLE);
            if (ar_fire) begin
                addr_q   <= s_axi_araddr;
                len_q    <= s_axi_arlen;
                size_q   <= s_axi_arsize;
                burst_q  <= s_axi_arburst;
                beat_cnt <= s_axi_arlen;
                lat_cnt  <= 8'(READ_LATENCY - 1);
            end else if (state == WAIT && lat_cnt != 8'd0) begin
                lat_cnt <= lat_cnt - 8'd1;
            end
            if (r_fire && beat_cnt != 8'd0) begin
                addr_q   <= step_addr;
                beat_cnt <= beat_cnt - 8'd1;
            end
        end
    end

`ifdef AXI_RESP_ERR_EN
    logic err_q;

    function automatic logic in_range(input logic [63:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (AW + 3)) == 64'd0);
    endfunction

    // The error flag travels with the registered read so it lines up with its beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (rd_en) begin
            err_q <= !in_range(rd_addr);
        end
    end

    assign s_axi_rdata = err_q ? ERR_DATA : mem_q;
    assign s_axi_rresp = err_q ? RESP_SLVERR : RESP_OKAY;
    assign ld_we       = ld_en && in_range(ld_addr);
`else
    assign s_axi_rdata = mem_q;
    assign s_axi_rresp = RESP_OKAY;
    assign ld_we       = ld_en;
`endif

    axi_resp_mem #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_idx  (word_idx(rd_addr)),
        .rd_data (mem_q),
        .wr_en   (ld_we),
        .wr_idx  (word_idx(ld_addr)),
        .wr_data (ld_data)
    );

endmodule
